// File: rtl/rmt_wrapper.sv
// rmt_wrapper: single-stage match-action block on an AXI-Stream packet path.
// Beat 0 of each packet is parsed. UDP config packets (dst port 0xF1F2) program
// the op table and are dropped. Data packets that hit a valid entry get bytes
// 56-59 overwritten with (A op B). The output is one register stage with
// standard valid/ready backpressure.
// Optional build macro: RMT_CSUM_ZERO_EN zeroes the UDP checksum (bytes 44-45)
// of every modified packet.
module rmt_wrapper #(
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = 512,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned C_M_AXIS_DATA_WIDTH  = 512,
    parameter int unsigned C_S_AXI_DATA_WIDTH   = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH   = 12,
    parameter logic [31:0] C_BASEADDR           = 32'h80000000,
    parameter int unsigned PHV_ADDR_WIDTH       = 4
) (
    input  logic                              clk,
    input  logic                              aresetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast
);

    localparam int unsigned DATA_W  = C_M_AXIS_DATA_WIDTH;
    localparam int unsigned KEEP_W  = DATA_W / 8;
    localparam int unsigned USER_W  = C_S_AXIS_TUSER_WIDTH;
    localparam int unsigned ENTRIES = 1 << PHV_ADDR_WIDTH;
    localparam int unsigned KEY_W   = 16;
    localparam int unsigned OP_W    = 8;
    localparam int unsigned WORD_W  = 32;

    // Byte offsets inside beat 0
    localparam int unsigned VLAN_TPID_OFF = 12;
    localparam int unsigned ETHTYPE_OFF   = 16;
    localparam int unsigned IP_PROTO_OFF  = 27;
    localparam int unsigned DPORT_OFF     = 40;
    localparam int unsigned CSUM_OFF      = 44;
    localparam int unsigned IDX_OFF       = 46;
    localparam int unsigned CKEY_OFF      = 47;
    localparam int unsigned COP_OFF       = 49;
    localparam int unsigned CVLD_OFF      = 50;
    localparam int unsigned DKEY_OFF      = 46;
    localparam int unsigned OPA_OFF       = 48;
    localparam int unsigned OPB_OFF       = 52;
    localparam int unsigned RES_OFF       = 56;

    localparam logic [OP_W-1:0] OP_ADD = 8'd1;
    localparam logic [OP_W-1:0] OP_SUB = 8'd2;
    localparam logic [OP_W-1:0] OP_AND = 8'd3;
    localparam logic [OP_W-1:0] OP_OR  = 8'd4;
    localparam logic [OP_W-1:0] OP_XOR = 8'd5;

`ifdef RMT_CSUM_ZERO_EN
    localparam bit CSUM_ZERO = 1'b1;
`else
    localparam bit CSUM_ZERO = 1'b0;
`endif

    // Reserved AXI-Lite parameters have no function here
    logic unused_c;
    assign unused_c = ^{C_S_AXI_DATA_WIDTH, C_S_AXI_ADDR_WIDTH, C_BASEADDR};

    function automatic logic [7:0] pkt_byte(input logic [DATA_W-1:0] d, input int unsigned n);
        return d[8*n +: 8];
    endfunction

    function automatic logic [15:0] be16(input logic [DATA_W-1:0] d, input int unsigned n);
        return {pkt_byte(d, n), pkt_byte(d, n + 1)};
    endfunction

    function automatic logic [31:0] be32(input logic [DATA_W-1:0] d, input int unsigned n);
        return {be16(d, n), be16(d, n + 2)};
    endfunction

    // Packet-position state and table
    logic                        beat0_q, beat0_d;
    logic                        drop_q, drop_d;
    logic [KEY_W-1:0]            tbl_key_q [ENTRIES];
    logic [OP_W-1:0]             tbl_op_q  [ENTRIES];
    logic [ENTRIES-1:0]          tbl_vld_q;

    // Output register stage
    logic                        m_valid_q, m_valid_d;
    logic [DATA_W-1:0]           m_data_q, m_data_d;
    logic [KEEP_W-1:0]           m_keep_q, m_keep_d;
    logic [USER_W-1:0]           m_user_q, m_user_d;
    logic                        m_last_q, m_last_d;

    logic                        s_ready_c;
    logic                        accept_c;
    logic                        is_udp_c;
    logic                        is_cfg_c;
    logic                        cfg_wr_c;
    logic [PHV_ADDR_WIDTH-1:0]   cfg_idx_c;
    logic [KEY_W-1:0]            data_key_c;
    logic                        hit_c;
    logic [OP_W-1:0]             hit_op_c;
    logic [WORD_W-1:0]           op_a_c, op_b_c;
    logic [WORD_W-1:0]           alu_res_c;
    logic                        alu_en_c;
    logic                        modify_c;
    logic                        drop_beat_c;
    logic [DATA_W-1:0]           mod_data_c;

    assign s_ready_c     = !m_valid_q || m_axis_tready;
    assign accept_c      = s_axis_tvalid && s_ready_c;
    assign s_axis_tready = s_ready_c;

    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tkeep  = m_keep_q;
    assign m_axis_tuser  = m_user_q;
    assign m_axis_tlast  = m_last_q;

    // Header classification and field extraction from the current beat
    always_comb begin
        is_udp_c   = (be16(s_axis_tdata, VLAN_TPID_OFF) == 16'h8100) &&
                     (be16(s_axis_tdata, ETHTYPE_OFF) == 16'h0800) &&
                     (pkt_byte(s_axis_tdata, IP_PROTO_OFF) == 8'h11);
        is_cfg_c   = is_udp_c && (be16(s_axis_tdata, DPORT_OFF) == 16'hF1F2);
        cfg_idx_c  = s_axis_tdata[8*IDX_OFF +: PHV_ADDR_WIDTH];
        data_key_c = be16(s_axis_tdata, DKEY_OFF);
        op_a_c     = be32(s_axis_tdata, OPA_OFF);
        op_b_c     = be32(s_axis_tdata, OPB_OFF);
    end

    // Parallel key match against the pre-write table; lowest index wins
    always_comb begin
        hit_c    = 1'b0;
        hit_op_c = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (tbl_vld_q[i] && (tbl_key_q[i] == data_key_c)) begin
                hit_c    = 1'b1;
                hit_op_c = tbl_op_q[i];
            end
        end
    end

    // 32-bit action unit; unknown opcodes behave as NOP
    always_comb begin
        alu_en_c  = 1'b1;
        alu_res_c = '0;
        case (hit_op_c)
            OP_ADD:  alu_res_c = op_a_c + op_b_c;
            OP_SUB:  alu_res_c = op_a_c - op_b_c;
            OP_AND:  alu_res_c = op_a_c & op_b_c;
            OP_OR:   alu_res_c = op_a_c | op_b_c;
            OP_XOR:  alu_res_c = op_a_c ^ op_b_c;
            default: alu_en_c  = 1'b0;
        endcase
    end

    // Rewrite of the result field (and optionally the checksum) on a hit
    always_comb begin
        modify_c   = beat0_q && is_udp_c && !is_cfg_c && hit_c && alu_en_c &&
                     s_axis_tkeep[RES_OFF + 3];
        mod_data_c = s_axis_tdata;
        if (modify_c) begin
            for (int i = 0; i < 4; i++) begin
                mod_data_c[8*(RES_OFF + i) +: 8] = alu_res_c[8*(3 - i) +: 8];
            end
            if (CSUM_ZERO) begin
                mod_data_c[8*CSUM_OFF +: 16] = '0;
            end
        end
    end

    // Next-state for packet tracking and the output stage
    always_comb begin
        beat0_d     = beat0_q;
        drop_d      = drop_q;
        cfg_wr_c    = 1'b0;
        drop_beat_c = 1'b0;
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        m_keep_d    = m_keep_q;
        m_user_d    = m_user_q;
        m_last_d    = m_last_q;
        if (s_ready_c) begin
            m_valid_d = 1'b0;
        end
        if (accept_c) begin
            beat0_d = s_axis_tlast;
            if (beat0_q) begin
                drop_beat_c = is_cfg_c;
                cfg_wr_c    = is_cfg_c;
                drop_d      = is_cfg_c && !s_axis_tlast;
            end else begin
                drop_beat_c = drop_q;
                if (s_axis_tlast) begin
                    drop_d = 1'b0;
                end
            end
            if (!drop_beat_c) begin
                m_valid_d = 1'b1;
                m_data_d  = mod_data_c;
                m_keep_d  = s_axis_tkeep;
                m_user_d  = s_axis_tuser;
                m_last_d  = s_axis_tlast;
            end
        end
    end

    // Packet-position and output registers
    always_ff @(posedge clk or posedge aresetn) begin
        if (aresetn) begin
            beat0_q   <= 1'b1;
            drop_q    <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_keep_q  <= '0;
            m_user_q  <= '0;
            m_last_q  <= 1'b0;
        end else begin
            beat0_q   <= beat0_d;
            drop_q    <= drop_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_keep_q  <= m_keep_d;
            m_user_q  <= m_user_d;
            m_last_q  <= m_last_d;
        end
    end

    // Op table write from config beat 0
    always_ff @(posedge clk or posedge aresetn) begin
        if (aresetn) begin
            tbl_vld_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_key_q[i] <= '0;
                tbl_op_q[i]  <= '0;
            end
        end else if (cfg_wr_c) begin
            tbl_key_q[cfg_idx_c] <= be16(s_axis_tdata, CKEY_OFF);
            tbl_op_q[cfg_idx_c]  <= pkt_byte(s_axis_tdata, COP_OFF);
            tbl_vld_q[cfg_idx_c] <= s_axis_tdata[8*CVLD_OFF];
        end
    end

endmodule

// File: tb/tb_rmt_wrapper.sv
// tb_rmt_wrapper: scoreboard bench for rmt_wrapper with a byte-level packet model.
`timescale 1ns/1ps
module tb_rmt_wrapper;

    logic         clk = 1'b0;
    logic         aresetn = 1'b1;
    logic [511:0] s_axis_tdata = '0;
    logic [63:0]  s_axis_tkeep = '0;
    logic [127:0] s_axis_tuser = '0;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tready;
    logic         s_axis_tlast = 1'b0;
    logic [511:0] m_axis_tdata;
    logic [63:0]  m_axis_tkeep;
    logic [127:0] m_axis_tuser;
    logic         m_axis_tvalid;
    logic         m_axis_tready = 1'b1;
    logic         m_axis_tlast;

    rmt_wrapper dut (
        .clk(clk), .aresetn(aresetn),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [511:0] d;
        logic [63:0]  k;
        logic [127:0] u;
        logic         l;
    } beat_t;

    beat_t        exp_q[$];
    int           errs = 0;
    int           checks = 0;
    int           n_out = 0;
    int           stall_cnt = 0;
    bit           rand_ready = 1'b0;
    logic [511:0] last_out = '0;

    // Reference model state: packet position and the op table
    bit           mdl_beat0 = 1'b1;
    bit           mdl_drop = 1'b0;
    logic [15:0]  tk [16];
    logic [7:0]   top [16];
    bit           tv [16];

    logic [15:0]  key_pool [6] = '{16'h001A, 16'h000D, 16'h0BEE, 16'h7777, 16'h4242, 16'h1234};

    task automatic check(input string nm, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [511:0] put_be(logic [511:0] d, int n, int nb, logic [31:0] v);
        for (int i = 0; i < nb; i++) d[8*(n+i) +: 8] = v[8*(nb-1-i) +: 8];
        return d;
    endfunction

    function automatic logic [31:0] get_be(logic [511:0] d, int n, int nb);
        logic [31:0] v = '0;
        for (int i = 0; i < nb; i++) v = (v << 8) | 32'(d[8*(n+i) +: 8]);
        return v;
    endfunction

    function automatic logic [511:0] rnd512();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    // hk = 0 gives a valid VLAN/IPv4/UDP header, 1..3 break one field
    function automatic logic [511:0] hdr(int hk, logic [15:0] dport);
        logic [511:0] d = rnd512();
        d = put_be(d, 12, 2, 32'h8100);
        d = put_be(d, 16, 2, 32'h0800);
        d = put_be(d, 27, 1, 32'h11);
        d = put_be(d, 40, 2, 32'(dport));
        case (hk)
            1: d = put_be(d, 12, 1, 32'h88);
            2: d = put_be(d, 17, 1, 32'h06);
            3: d = put_be(d, 27, 1, 32'h06);
            default: ;
        endcase
        return d;
    endfunction

    function automatic logic [511:0] cfg_pkt(int hk, logic [7:0] idx, logic [15:0] key, logic [7:0] op, bit vld);
        logic [511:0] d = hdr(hk, 16'hF1F2);
        d = put_be(d, 46, 1, 32'(idx));
        d = put_be(d, 47, 2, 32'(key));
        d = put_be(d, 49, 1, 32'(op));
        d = put_be(d, 50, 1, {24'h0, 7'($urandom), vld});
        return d;
    endfunction

    function automatic logic [511:0] data_pkt(int hk, logic [15:0] key, logic [31:0] a, logic [31:0] b);
        logic [511:0] d = hdr(hk, 16'h0035);
        d = put_be(d, 46, 2, 32'(key));
        d = put_be(d, 48, 4, a);
        d = put_be(d, 52, 4, b);
        return d;
    endfunction

    // Behavioural model of one accepted input beat
    function automatic void model_beat(logic [511:0] d, logic [63:0] k, logic [127:0] u, logic l);
        logic [7:0]  b [64];
        bit          udp, cfg, hit;
        int          hi;
        logic [31:0] a, bb, r;
        beat_t       e;
        for (int i = 0; i < 64; i++) b[i] = d[8*i +: 8];
        udp = ({b[12], b[13]} == 16'h8100) && ({b[16], b[17]} == 16'h0800) && (b[27] == 8'h11);
        cfg = udp && ({b[40], b[41]} == 16'hF1F2);
        e.d = d; e.k = k; e.u = u; e.l = l;
        if (mdl_beat0) begin
            if (cfg) begin
                tk[b[46] % 16]  = {b[47], b[48]};
                top[b[46] % 16] = b[49];
                tv[b[46] % 16]  = b[50][0];
                mdl_drop = !l;
            end else begin
                hit = 0; hi = 0;
                for (int i = 15; i >= 0; i--)
                    if (tv[i] && tk[i] == {b[46], b[47]}) begin hit = 1; hi = i; end
                a  = {b[48], b[49], b[50], b[51]};
                bb = {b[52], b[53], b[54], b[55]};
                if (udp && hit && k[59] && top[hi] >= 1 && top[hi] <= 5) begin
                    case (top[hi])
                        1: r = a + bb;
                        2: r = a - bb;
                        3: r = a & bb;
                        4: r = a | bb;
                        default: r = a ^ bb;
                    endcase
                    e.d = put_be(e.d, 56, 4, r);
`ifdef RMT_CSUM_ZERO_EN
                    e.d = put_be(e.d, 44, 2, 32'h0);
`endif
                end
                exp_q.push_back(e);
            end
        end else if (!mdl_drop) begin
            exp_q.push_back(e);
        end
        if (l) mdl_drop = 0;
        mdl_beat0 = l;
    endfunction

    task automatic send_beat(input logic [511:0] d, input logic [63:0] k, input logic [127:0] u, input logic l);
        int g = 0;
        @(negedge clk);
        s_axis_tdata = d; s_axis_tkeep = k; s_axis_tuser = u; s_axis_tlast = l; s_axis_tvalid = 1'b1;
        while (!s_axis_tready && g < 1000) begin @(negedge clk); g++; end
        if (!s_axis_tready) begin
            checks++; errs++;
            $display("FAIL send_timeout: s_axis_tready stuck at 0 for %0d cycles", g);
            s_axis_tvalid = 1'b0;
            return;
        end
        model_beat(d, k, u, l);
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input logic [511:0] d0, input logic [63:0] k0, input int nb);
        for (int i = 0; i < nb; i++) begin
            logic [511:0] d = d0;
            logic [63:0]  k = k0;
            if (i > 0) begin d = rnd512(); k = '1; end
            if (i > 0 && i == nb - 1) k = {64{1'b1}} >> $urandom_range(0, 63);
            send_beat(d, k, {$urandom, $urandom, $urandom, $urandom}, i == nb - 1);
        end
    endtask

    task automatic drain();
        int g = 0;
        while (exp_q.size() > 0 && g < 2000) begin @(negedge clk); g++; end
        checks++;
        if (exp_q.size() > 0) begin
            errs++;
            $display("FAIL drain_timeout: %0d beats still expected", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        aresetn = 1'b1;
        exp_q.delete();
        mdl_beat0 = 1; mdl_drop = 0;
        for (int i = 0; i < 16; i++) begin tk[i] = '0; top[i] = '0; tv[i] = 0; end
        @(posedge clk); #1;
        check("rst_tvalid", 512'(m_axis_tvalid), 512'd0);
        check("rst_tdata", m_axis_tdata, 512'd0);
        check("rst_tkeep", 512'(m_axis_tkeep), 512'd0);
        check("rst_tuser", 512'(m_axis_tuser), 512'd0);
        check("rst_tlast", 512'(m_axis_tlast), 512'd0);
        @(negedge clk);
        aresetn = 1'b0;
        @(negedge clk);
        check("rst_tready", 512'(s_axis_tready), 512'd1);
    endtask

    // Sink-side ready: random, forced stall, or always ready
    initial begin
        forever begin
            @(posedge clk); #1;
            if (stall_cnt > 0) begin m_axis_tready = 1'b0; stall_cnt--; end
            else if (rand_ready) m_axis_tready = ($urandom_range(0, 3) != 0);
            else m_axis_tready = 1'b1;
        end
    end

    // Monitor: holds stability while stalled, pops and compares on each transfer
    initial begin
        bit           held = 0;
        logic [511:0] hd;
        logic [63:0]  hk;
        logic [127:0] hu;
        logic         hl;
        beat_t        e;
        forever begin
            @(negedge clk);
            if (aresetn) begin
                held = 0;
            end else begin
                if (held) begin
                    checks++;
                    if (!m_axis_tvalid || m_axis_tdata !== hd || m_axis_tkeep !== hk ||
                        m_axis_tuser !== hu || m_axis_tlast !== hl) begin
                        errs++;
                        $display("FAIL hold_stable: valid=%0b tdata %0h held %0h", m_axis_tvalid, m_axis_tdata, hd);
                    end
                end
                held = 0;
                if (m_axis_tvalid && !m_axis_tready) begin
                    check("stall_s_tready", 512'(s_axis_tready), 512'd0);
                    held = 1; hd = m_axis_tdata; hk = m_axis_tkeep; hu = m_axis_tuser; hl = m_axis_tlast;
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errs++;
                        $display("FAIL unexpected_beat: got tdata %0h with no beat expected", m_axis_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        if (m_axis_tdata !== e.d || m_axis_tkeep !== e.k || m_axis_tuser !== e.u || m_axis_tlast !== e.l) begin
                            errs++;
                            $display("FAIL out_beat%0d: tdata %0h exp %0h keep %0h exp %0h last %0b exp %0b",
                                     n_out, m_axis_tdata, e.d, m_axis_tkeep, e.k, m_axis_tlast, e.l);
                        end
                    end
                    last_out = m_axis_tdata;
                    n_out++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errs + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        logic [511:0] d;
        int           n0;
        do_reset();

        // SUB hit: 3 - 2 = 1, with 1-cycle latency
        send_pkt(cfg_pkt(0, 8'd0, 16'h001A, 8'd2, 1'b1), '1, 1);
        check("cfg_no_output", 512'(m_axis_tvalid), 512'd0);
        d = data_pkt(0, 16'h001A, 32'd3, 32'd2);
        send_pkt(d, '1, 1);
        check("latency_sub", 512'(m_axis_tvalid), 512'd1);
        drain();
        check("sub_result", 512'(get_be(last_out, 56, 4)), 512'h00000001);

        // ADD hit: 3 + 2 = 5, checksum handling
        send_pkt(cfg_pkt(0, 8'd1, 16'h000D, 8'd1, 1'b1), '1, 1);
        d = data_pkt(0, 16'h000D, 32'd3, 32'd2);
        send_pkt(d, '1, 1);
        check("latency_add", 512'(m_axis_tvalid), 512'd1);
        drain();
        check("add_result", 512'(get_be(last_out, 56, 4)), 512'h00000005);
`ifdef RMT_CSUM_ZERO_EN
        check("csum_zeroed", 512'(get_be(last_out, 44, 2)), 512'h0);
`else
        check("csum_kept", 512'(get_be(last_out, 44, 2)), 512'(get_be(d, 44, 2)));
`endif

        // SUB wrap-around and an unconfigured key
        send_pkt(data_pkt(0, 16'h001A, 32'd0, 32'd1), '1, 1);
        drain();
        check("sub_wrap", 512'(get_be(last_out, 56, 4)), 512'hFFFFFFFF);
        d = data_pkt(0, 16'h1234, 32'd7, 32'd9);
        send_pkt(d, '1, 1);
        drain();
        check("miss_passthru", last_out, d);

        // Two-beat config packet is fully dropped, then its entry hits (XOR)
        send_beat(cfg_pkt(0, 8'd2, 16'h0BEE, 8'd5, 1'b1), '1, '0, 1'b0);
        check("cfg2_beat0_drop", 512'(m_axis_tvalid), 512'd0);
        send_beat(rnd512(), '1, '0, 1'b1);
        check("cfg2_beat1_drop", 512'(m_axis_tvalid), 512'd0);
        // Higher index with the same key must lose to index 2
        send_pkt(cfg_pkt(0, 8'd5, 16'h0BEE, 8'd1, 1'b1), '1, 1);
        send_pkt(data_pkt(0, 16'h0BEE, 32'hF0F0F0F0, 32'h0FF00FF0), '1, 1);
        drain();
        check("xor_lowest_idx", 512'(get_be(last_out, 56, 4)), 512'hFF00FF00);

        // Five-cycle sink stall mid-stream; no beat lost or duplicated
        n0 = n_out;
        send_pkt(data_pkt(0, 16'h000D, 32'd10, 32'd20), '1, 1);
        stall_cnt = 5;
        for (int i = 0; i < 5; i++) send_pkt(data_pkt(0, key_pool[i], $urandom, $urandom), '1, 1);
        drain();
        check("stall_beat_count", 512'(n_out - n0), 512'd6);

        // Reset in the middle of a data packet and of a config packet
        send_beat(data_pkt(0, 16'h000D, 32'd1, 32'd1), '1, '0, 1'b0);
        drain();
        do_reset();
        send_pkt(cfg_pkt(0, 8'd4, 16'h4242, 8'd3, 1'b1), '1, 1);
        send_pkt(data_pkt(0, 16'h4242, 32'hFFFF0000, 32'h0F0F0F0F), '1, 1);
        drain();
        check("post_rst_and", 512'(get_be(last_out, 56, 4)), 512'h0F0F0000);
        send_beat(cfg_pkt(0, 8'd3, 16'h7777, 8'd1, 1'b1), '1, '0, 1'b0);
        drain();
        do_reset();
        d = data_pkt(0, 16'h7777, 32'd1, 32'd2);
        send_pkt(d, '1, 1);
        drain();
        check("post_rst_cleared", last_out, d);

        // Randomized traffic with random backpressure
        rand_ready = 1'b1;
        for (int p = 0; p < 200; p++) begin
            int hk = ($urandom_range(0, 99) < 85) ? 0 : int'($urandom_range(1, 3));
            int nb = $urandom_range(1, 3);
            logic [63:0] k0 = ($urandom_range(0, 9) == 0) ? 64'h07FF_FFFF_FFFF_FFFF : '1;
            logic [15:0] key = key_pool[$urandom_range(0, 5)];
            if ($urandom_range(0, 9) < 3)
                send_pkt(cfg_pkt(hk, 8'($urandom), key, 8'($urandom_range(0, 7)),
                                 $urandom_range(0, 4) != 0), k0, nb);
            else
                send_pkt(data_pkt(hk, key, $urandom, $urandom), k0, nb);
        end
        drain();
        rand_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
